// File: rtl/arb_pkg.sv
// Shared constants, state encoding and the round-robin search helper for rr_arbiter_dec4.
// Pure declarations: no latency, no backpressure.
package arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Returns {found, index} of the first set bit of r scanning upward from start, wrapping 3->0.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   start);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] k;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = start + IDX_W'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction
endpackage

// File: rtl/arb_dec2to4.sv
// 2-to-4 one-hot decoder with enable; drives the grant select lines from the grant index.
// Combinational, zero latency; no backpressure.
module arb_dec2to4
    import arb_pkg::*;
(
    input  logic               en_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [NUM_REQ-1:0] dec_o
);
    assign dec_o = en_i ? (NUM_REQ'(1) << idx_i) : '0;
endmodule

// File: rtl/rr_arbiter_dec4.sv
// Four-requester round-robin arbiter, grant held until release; ARB_TIMEOUT_EN adds a forced rotation after MAX_HOLD cycles.
// One-cycle latency from request to grant; back-to-back re-grant on release with no idle cycle.
// en low blocks new grants only; a live grant runs until its requester drops req.
module rr_arbiter_dec4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD  = 16,
    parameter int RESET_PTR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               hold_expired
);
    if (MAX_HOLD < 2 || MAX_HOLD > (2**CNT_W) - 1) begin : g_bad_max_hold
        $error("MAX_HOLD out of range 2..255");
    end
    if (RESET_PTR < 0 || RESET_PTR > NUM_REQ - 1) begin : g_bad_reset_ptr
        $error("RESET_PTR out of range 0..3");
    end

    logic [0:0]         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] others;
    logic [IDX_W:0]     pick_idle, pick_rel;
    logic               expire;

    // Release and forced rotation share one search that skips the current holder.
    assign others    = req & ~(NUM_REQ'(1) << idx_q);
    assign pick_idle = rr_pick(req, ptr_q);
    assign pick_rel  = rr_pick(others, idx_q + IDX_W'(1));

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             he_q;

    assign expire = (cnt_q >= HOLD_LAST) && pick_rel[IDX_W] && en;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != GRANT || idx_d != idx_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            he_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            he_q  <= (state_q == GRANT) && req[idx_q] && expire;
        end
    end

    assign hold_expired = he_q;
`else
    assign expire       = 1'b0;
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (en && pick_idle[IDX_W]) begin
                    state_d = GRANT;
                    idx_d   = pick_idle[IDX_W-1:0];
                end
            end
            default: begin
                if (!req[idx_q]) begin
                    ptr_d = idx_q + IDX_W'(1);
                    if (en && pick_rel[IDX_W]) begin
                        idx_d = pick_rel[IDX_W-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end else if (expire) begin
                    ptr_d = idx_q + IDX_W'(1);
                    idx_d = pick_rel[IDX_W-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(RESET_PTR);
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = idx_q;

    arb_dec2to4 u_dec (
        .en_i  (gnt_valid),
        .idx_i (idx_q),
        .dec_o (gnt)
    );
endmodule

// File: doc/rr_arbiter_dec4.md
Name: rr_arbiter_dec4

Overview:
- Four-requester round-robin arbiter for a shared resource.
- Selects one requester and holds the grant until that requester releases it.
- Produces a 2-bit grant index, plus a one-hot grant vector built by a 2-to-4 line decode of that index.
- Sits in front of any shared datapath or bus whose select lines are decoder-driven.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles before a forced rotation. Used only when ARB_TIMEOUT_EN is defined; legal range 2..255.
- RESET_PTR, 0: requester index searched first after reset (0..3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- en  input  1  arbitration enable. Low blocks new grants; an existing grant continues.
- req  input  4  request vector; bit i = requester i.
- gnt  output  4  one-hot grant; all zeros when idle.
- gnt_idx  output  2  index of the granted requester.
- gnt_valid  output  1  high while any grant is active.
- hold_expired  output  1  one-cycle pulse on a forced rotation. Tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values:
  - state=IDLE, ptr=RESET_PTR.
  - gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, hold_expired=0.
  - Reset asserted mid-grant clears everything immediately, without waiting for a clock edge.
- Search rule: scan req starting at ptr, ascending with wrap 3->0. The first set bit wins. ptr always equals (last granted index + 1) mod 4; 2-bit arithmetic wraps naturally.
- Decode: gnt = one-hot of gnt_idx when gnt_valid=1, else 0. gnt is never multi-hot.
- State IDLE:
  - If en=1 and req!=0 at the edge, go to GRANT with the winner index; gnt_valid=1 after that edge (1-cycle latency).
  - Otherwise stay in IDLE.
- State GRANT:
  - Hold while req[gnt_idx]=1; other requests are ignored.
  - Release when req[gnt_idx]=0 at an edge:
    - ptr <= gnt_idx+1.
    - If en=1 and any other req is set, re-grant in the same edge with no idle cycle (back-to-back). The search starts at gnt_idx+1 and excludes the releasing index.
    - Otherwise go to IDLE and clear gnt/gnt_valid.
- en low during GRANT: the grant persists until release, then the block goes to IDLE.
- Simultaneous drop and re-raise: a requester dropping and re-raising req across consecutive cycles is not re-granted at the release edge. It can win at the next edge if it is the only requester.
- req changing while IDLE with en=0: no effect.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter resets to 0 on each new grant and increments every GRANT cycle.
  - When the counter reaches MAX_HOLD-1, req[gnt_idx] is still 1, and another requester is pending, the block forces rotation to the next requester by the normal search, excluding the current index.
  - hold_expired pulses for one cycle, coincident with the new gnt_idx.
  - If no other requester is pending, the grant continues, the counter saturates, and there is no pulse.
- Not defined:
  - No counter is present; grants are held indefinitely.
  - hold_expired is constant 0 and MAX_HOLD is ignored.

Decomposition:
- Package arb_pkg:
  - NUM_REQ=4, IDX_W=2.
  - State encoding IDLE=1'b0, GRANT=1'b1.
  - CNT_W=8 for the hold counter.
- Sub-module arb_dec2to4: combinational 2-to-4 one-hot decode with enable (gnt_valid), driving gnt from gnt_idx.
- The round-robin search stays in the top level.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 -> gnt=0000, gnt_valid=0. Release reset, then one edge -> gnt=0001, gnt_idx=0.
- Round-robin: req=4'b1111 held; each granted requester drops req for exactly one cycle in turn -> grant order 0,1,2,3,0 with no idle cycle between grants.
- Wrap and skip: ptr=3, req=4'b0101 -> grant idx 0. After release, req=4'b0100 -> grant idx 2.
- Hold and en:
  - req[1] held 40 cycles with req[3] also set -> gnt=0010 throughout (no macro).
  - Drop req[1] with en=0 -> IDLE, gnt=0000.
  - en=1 -> gnt=1000 one cycle later.
- Async reset mid-grant: assert rst_n=0 between clock edges while gnt=0100 -> gnt=0000 immediately. After release, first grant follows RESET_PTR ordering.
- ARB_TIMEOUT_EN with MAX_HOLD=4: req=4'b0011 held -> idx0 for 4 cycles, hold_expired pulse, idx1 for 4 cycles, pulse, idx0. With req=4'b0001 only -> idx0 held, no pulse.
